// File: rtl/ka131_mul_arbiter.sv
// Round-robin sequencer sharing one combinational 131-bit carry-less multiplier core
// among N_REQ requesters: grant, settle for MUL_WAIT cycles, capture, respond.
module ka131_mul_arbiter #(
    parameter int N_REQ    = 4,
    parameter int W        = 131,
    parameter int MUL_WAIT = 2,
    parameter int IDW      = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [N_REQ*W-1:0] req_a,
    input  logic [N_REQ*W-1:0] req_b,
    output logic [W-1:0]       mul_a,
    output logic [W-1:0]       mul_b,
    input  logic [2*W-2:0]     mul_y,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [IDW-1:0]     rsp_id,
    output logic [2*W-2:0]     rsp_y,
    output logic               busy
);
    localparam int CW = (MUL_WAIT > 1) ? $clog2(MUL_WAIT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t         state;
    state_t         state_next;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] ptr_next;
    logic [IDW-1:0] grant;
    logic           grant_vld;
    logic [CW-1:0]  cnt;

    // First active requester at or after ptr, wrapping modulo N_REQ.
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!grant_vld && req_valid[(int'(ptr) + i) % N_REQ]) begin
                grant     = IDW'((int'(ptr) + i) % N_REQ);
                grant_vld = 1'b1;
            end
        end
        ptr_next = (int'(grant) == N_REQ - 1) ? '0 : grant + 1'b1;
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && grant_vld) begin
            req_ready[grant] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (grant_vld) state_next = WAIT;
            WAIT: if (cnt == '0) state_next = RESP;
            RESP: if (rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Core operands only move on a grant, so mul_y is stable through WAIT and RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            cnt       <= '0;
            mul_a     <= '0;
            mul_b     <= '0;
            rsp_y     <= '0;
            rsp_id    <= '0;
            rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_vld) begin
                        mul_a  <= req_a[int'(grant)*W +: W];
                        mul_b  <= req_b[int'(grant)*W +: W];
                        rsp_id <= grant;
                        ptr    <= ptr_next;
                        cnt    <= CW'(MUL_WAIT - 1);
                    end
                end
                WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        rsp_y     <= mul_y;
                        rsp_valid <= 1'b1;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_ka131_mul_arbiter.sv
// Self-checking bench for ka131_mul_arbiter: behavioural carry-less core on mul_y,
// a cycle model of the arbiter, and a scoreboard of expected responses.
module tb_ka131_mul_arbiter;
    localparam int N_REQ    = 4;
    localparam int W        = 131;
    localparam int MUL_WAIT = 2;
    localparam int IDW      = 2;
    localparam int YW       = 2*W - 1;

    logic               clk;
    logic               rst_n;
    logic [N_REQ-1:0]   req_valid;
    logic [N_REQ-1:0]   req_ready;
    logic [N_REQ*W-1:0] req_a;
    logic [N_REQ*W-1:0] req_b;
    logic [W-1:0]       mul_a;
    logic [W-1:0]       mul_b;
    logic [YW-1:0]      mul_y;
    logic               rsp_valid;
    logic               rsp_ready;
    logic [IDW-1:0]     rsp_id;
    logic [YW-1:0]      rsp_y;
    logic               busy;

    typedef struct {
        int            id;
        logic [W-1:0]  a;
        logic [W-1:0]  b;
        logic [YW-1:0] y;
    } vec_t;

    typedef struct {
        logic [IDW-1:0] id;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic [YW-1:0]  y;
    } exp_t;

    typedef enum {M_IDLE, M_WAIT, M_RESP} m_phase_t;

    vec_t          vecs[4];
    exp_t          sb[$];
    logic [W-1:0]  op_a[N_REQ];
    logic [W-1:0]  op_b[N_REQ];
    logic [YW-1:0] exp_prod[N_REQ];
    m_phase_t      m_phase;
    int            m_ptr;
    int            m_cnt;
    bit            auto_drop;
    int            n_vec;
    int            n_fail;

    ka131_mul_arbiter #(.N_REQ(N_REQ), .W(W), .MUL_WAIT(MUL_WAIT), .IDW(IDW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_y(rsp_y), .busy(busy)
    );

    function automatic logic [YW-1:0] clmul(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [YW-1:0] r;
        r = '0;
        for (int i = 0; i < W; i++) begin
            if (b[i]) r = r ^ (YW'(a) << i);
        end
        return r;
    endfunction

    function automatic logic [W-1:0] rand_op();
        logic [159:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
        return r[W-1:0];
    endfunction

    always_comb mul_y = clmul(mul_a, mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [YW-1:0] act, input logic [YW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input int id, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [YW-1:0] y);
        op_a[id]          = a;
        op_b[id]          = b;
        exp_prod[id]      = y;
        req_a[id*W +: W]  = a;
        req_b[id*W +: W]  = b;
        req_valid[id]     = 1'b1;
    endtask

    task automatic check_reset();
        check_output("rst mul_a", YW'(mul_a), '0);
        check_output("rst mul_b", YW'(mul_b), '0);
        check_output("rst rsp_y", rsp_y, '0);
        check_output("rst rsp_id", YW'(rsp_id), '0);
        check_output("rst rsp_valid", YW'(rsp_valid), '0);
        check_output("rst busy", YW'(busy), '0);
        check_output("rst req_ready", YW'(req_ready), '0);
    endtask

    // One clock of the reference model: compare this cycle, then advance across the edge.
    task automatic run_cycle();
        logic [N_REQ-1:0] exp_ready;
        int               g;
        exp_t             e;
        #1;
        exp_ready = '0;
        g         = -1;
        check_output("busy", YW'(busy), YW'(m_phase != M_IDLE));
        if (m_phase == M_IDLE) begin
            for (int i = 0; i < N_REQ; i++) begin
                if (g < 0 && req_valid[(m_ptr + i) % N_REQ]) g = (m_ptr + i) % N_REQ;
            end
            if (g >= 0) exp_ready[g] = 1'b1;
        end
        check_output("req_ready", YW'(req_ready), YW'(exp_ready));
        if (m_phase == M_RESP) begin
            check_output("rsp_valid", YW'(rsp_valid), YW'(1'b1));
            if (sb.size() > 0) begin
                e = sb[0];
                check_output("rsp_id", YW'(rsp_id), YW'(e.id));
                check_output("rsp_y", rsp_y, e.y);
                check_output("mul_a", YW'(mul_a), YW'(e.a));
                check_output("mul_b", YW'(mul_b), YW'(e.b));
            end else begin
                n_vec++;
                n_fail++;
                $display("[TB] FAIL scoreboard: got empty expected entry");
            end
        end else begin
            check_output("rsp_valid", YW'(rsp_valid), '0);
        end
        case (m_phase)
            M_IDLE: if (g >= 0) begin
                e.id = IDW'(g);
                e.a  = op_a[g];
                e.b  = op_b[g];
                e.y  = exp_prod[g];
                sb.push_back(e);
                m_ptr   = (g + 1) % N_REQ;
                m_cnt   = MUL_WAIT;
                m_phase = M_WAIT;
            end
            M_WAIT: begin
                m_cnt--;
                if (m_cnt == 0) m_phase = M_RESP;
            end
            M_RESP: if (rsp_ready) begin
                if (sb.size() > 0) void'(sb.pop_front());
                m_phase = M_IDLE;
            end
            default: ;
        endcase
        @(posedge clk);
        #1;
        if (g >= 0 && auto_drop) req_valid[g] = 1'b0;
    endtask

    task automatic run_until_idle(input int max_cycles);
        int n;
        n = 0;
        do begin
            run_cycle();
            n++;
        end while (m_phase != M_IDLE && n < max_cycles);
        check_output("idle bound", YW'(m_phase != M_IDLE), '0);
    endtask

    initial begin
        logic [W-1:0]  ones;
        logic [W-1:0]  top;
        logic [YW-1:0] alt;
        logic [YW-1:0] ytop;
        logic [W-1:0]  ra;
        logic [W-1:0]  rb;

        n_vec     = 0;
        n_fail    = 0;
        m_phase   = M_IDLE;
        m_ptr     = 0;
        m_cnt     = 0;
        auto_drop = 1'b1;
        rst_n     = 1'b0;
        rsp_ready = 1'b1;
        req_a     = '0;
        req_b     = '0;
        req_valid = '1;
        for (int i = 0; i < N_REQ; i++) begin
            op_a[i] = '0; op_b[i] = '0; exp_prod[i] = '0;
        end

        ones = '1;
        top  = '0; top[W-1] = 1'b1;
        ytop = '0; ytop[YW-1] = 1'b1;
        alt  = '0;
        for (int i = 0; i < YW; i += 2) alt[i] = 1'b1;
        ra = rand_op();
        rb = rand_op();
        vecs[0] = '{id: 2, a: W'(3), b: W'(3), y: YW'(5)};
        vecs[1] = '{id: 0, a: ones, b: ones, y: alt};
        vecs[2] = '{id: 1, a: top, b: top, y: ytop};
        vecs[3] = '{id: 3, a: ra, b: rb, y: clmul(ra, rb)};

        #3;
        check_reset();
        repeat (2) @(posedge clk);
        #1;
        req_valid = '0;
        rst_n     = 1'b1;

        $display("[TB] single-request vectors");
        for (int v = 0; v < 4; v++) begin
            apply_stimulus(vecs[v].id, vecs[v].a, vecs[v].b, vecs[v].y);
            run_until_idle(20);
            run_cycle();
        end

        $display("[TB] round-robin with all requesters active");
        for (int i = 0; i < N_REQ; i++) begin
            ra = rand_op();
            rb = rand_op();
            apply_stimulus(i, ra, rb, clmul(ra, rb));
        end
        auto_drop = 1'b0;
        repeat (6 * (MUL_WAIT + 2)) run_cycle();
        req_valid = '0;
        auto_drop = 1'b1;
        run_until_idle(20);

        $display("[TB] response backpressure");
        rsp_ready = 1'b0;
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(2, ra, rb, clmul(ra, rb));
        repeat (MUL_WAIT + 1) run_cycle();
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(0, ra, rb, clmul(ra, rb));
        repeat (5) run_cycle();
        rsp_ready = 1'b1;
        repeat (2) run_cycle();
        run_until_idle(20);

        $display("[TB] reset during WAIT");
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(2, ra, rb, clmul(ra, rb));
        run_cycle();
        run_cycle();
        rst_n = 1'b0;
        #1;
        check_reset();
        sb.delete();
        m_phase = M_IDLE;
        m_ptr   = 0;
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(1, ra, rb, clmul(ra, rb));
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(3, ra, rb, clmul(ra, rb));
        #1;
        check_output("rst req_ready held", YW'(req_ready), '0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2 * (MUL_WAIT + 2) + 2) run_cycle();
        run_until_idle(20);

        $display("[TB] request withdrawal");
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(0, ra, rb, clmul(ra, rb));
        run_cycle();
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(1, ra, rb, clmul(ra, rb));
        ra = rand_op();
        rb = rand_op();
        apply_stimulus(3, ra, rb, clmul(ra, rb));
        run_cycle();
        req_valid[1] = 1'b0;
        repeat (3 * (MUL_WAIT + 2)) run_cycle();
        run_until_idle(20);
        check_output("scoreboard drained", YW'(sb.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/ka131_mul_arbiter.md
# ka131_mul_arbiter

Round-robin arbiter and sequencer that shares one combinational 131-bit Karatsuba carry-less multiplier core (GF(2)[x] polynomial product, 131×131 → 261 bits) among N_REQ requesters. It grants one request at a time and registers the operands onto the core inputs. It then waits a fixed multicycle settling window, captures the 261-bit product, and returns it with the requester ID over a valid/ready response channel. It sits between the field-arithmetic clients (point-add/double sequencers) and the single multiplier instance.

## Interface
- N_REQ, 4: number of requesters, 2..8.
- W, 131: operand width; product width is 2W-1.
- MUL_WAIT, 2: settling cycles allowed for the combinational core (multicycle path), ≥1.
- IDW, $clog2(N_REQ): requester ID width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  N_REQ  per-requester request valid.
- req_ready  out  N_REQ  per-requester grant/accept, one-hot or zero.
- req_a  in  N_REQ*W  operand A, requester i at [i*W +: W].
- req_b  in  N_REQ*W  operand B, same packing.
- mul_a  out  W  registered operand A to core.
- mul_b  out  W  registered operand B to core.
- mul_y  in  2W-1  core product (combinational from mul_a/mul_b).
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  IDW  ID of requester whose product is in rsp_y.
- rsp_y  out  2W-1  registered product.
- busy  out  1  high when state ≠ IDLE.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: if any req_valid, grant g = first index with req_valid set, searching from ptr upward with wrap modulo N_REQ. req_ready[g]=1 combinationally this cycle; all other bits 0. On the clock edge: mul_a←req_a[g], mul_b←req_b[g], rsp_id←g, ptr←(g+1) mod N_REQ, cnt←MUL_WAIT-1, and the state goes to WAIT. With no req_valid: stay in IDLE, req_ready=0.
- WAIT: req_ready=0. If cnt≠0, cnt decrements. If cnt==0: rsp_y←mul_y, rsp_valid←1, and the state goes to RESP.
- RESP: req_ready=0. rsp_valid, rsp_y and rsp_id are held stable until rsp_ready=1. On the edge with rsp_valid&rsp_ready: rsp_valid←0 and the state goes to IDLE.
- mul_a/mul_b change only on a grant edge, so core inputs are stable throughout WAIT and RESP.
- A requester must hold req_valid and its operands until it sees req_ready. Dropping req_valid before the grant is permitted and removes that requester from arbitration.
- No arithmetic is done in this block; rsp_y is mul_y bit-for-bit, 2W-1 bits, no truncation or extension.
- The response does not depend on req_valid after the grant.

## Timing
- Reset values (async, while rst_n=0): state IDLE, ptr 0, cnt 0, mul_a 0, mul_b 0, rsp_y 0, rsp_id 0, rsp_valid 0, busy 0. req_ready is forced to 0 while rst_n=0.
- Latency: the grant is on edge T. The product is captured and rsp_valid rises on edge T+MUL_WAIT.
- Earliest next grant is the cycle after the rsp handshake edge. Minimum period is MUL_WAIT+2 cycles per product with rsp_ready held at 1.
- The multicycle constraint mul_a/mul_b → rsp_y is MUL_WAIT cycles.
- Simultaneous requests: exactly one grant per IDLE cycle, in round-robin order from ptr.
- A requester that keeps req_valid high is granted again only after every other active requester has been served once.
- New requests arriving during WAIT/RESP are not granted until the state returns to IDLE. Requests are never lost provided the requester holds req_valid.
- Reset mid-operation (WAIT or RESP): the transaction is abandoned and no response is produced. After release, the block is in IDLE with ptr 0.
- ptr wrap: after granting index N_REQ-1, the search starts at 0.

## Test plan
- Single request, MUL_WAIT=2: requester 2 with a=3, b=3, others idle → req_ready=4'b0100 for 1 cycle. At T+2: rsp_valid=1, rsp_id=2, rsp_y=5 (carry-less product). One cycle after the handshake with rsp_ready=1, busy=0.
- Round-robin: all 4 req_valid held high, rsp_ready=1 → grants in order 0,1,2,3,0,1. Each response's rsp_id matches its grant. Successive grants are spaced by MUL_WAIT+2 cycles.
- Backpressure: rsp_ready=0 for 5 cycles in RESP → rsp_valid, rsp_y and rsp_id stay stable, and req_ready=0 throughout. Raising rsp_ready completes the handshake, and the next grant comes one cycle later.
- Full-width operands: a=b=all-ones (131 bits) → rsp_y has every even bit 0,2,…,260 set and every odd bit 0. Also a=1<<130, b=1<<130 → rsp_y=1<<260.
- Reset mid-WAIT: assert rst_n=0 one cycle after the grant → all outputs go to their reset values immediately. No rsp_valid appears after release. The next grant starts the search from index 0.
- Request withdrawal: requester 1 drops req_valid before its turn while requester 3 holds → requester 3 is granted and requester 1 receives no response.
